// File: rtl/fizzbuzz_stream.sv
`default_nettype none
// ============================================================================
// Module   : fizzbuzz_stream
// Purpose  : Multi-divisor fizzbuzz counter emitting a valid/ready beat stream.
// Revision : 1.0
// ============================================================================
module fizzbuzz_stream #(
  parameter int CNT_W   = 8,
  parameter int NUM_DIV = 3,
  parameter int DIV_W   = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     mode_wrap,
  input  logic [CNT_W-1:0]         cfg_limit,
  input  logic [NUM_DIV*DIV_W-1:0] cfg_div,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CNT_W-1:0]         out_count,
  output logic [NUM_DIV-1:0]       out_hit,
  output logic                     out_all,
  output logic                     out_none,
  output logic                     busy,
  output logic                     done
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t                         state, state_n;
  logic [CNT_W-1:0]               count, count_n;
  logic [CNT_W-1:0]               limit_q, limit_n;
  logic [NUM_DIV-1:0][DIV_W-1:0]  div_q, div_n;
  logic [NUM_DIV-1:0][DIV_W-1:0]  res, res_n;
  logic                           wrap_q, wrap_n;
  logic [NUM_DIV-1:0]             hit, hit_n;
  logic                           done_q, done_n;
  logic                           xfer;

  assign xfer = (state == S_RUN) && out_ready;

  always_comb begin
    state_n = state;
    count_n = count;
    res_n   = res;
    div_n   = div_q;
    limit_n = limit_q;
    wrap_n  = wrap_q;
    done_n  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_RUN;
          count_n = '0;
          res_n   = '0;
          div_n   = cfg_div;
          limit_n = cfg_limit;
          wrap_n  = mode_wrap;
        end
      end
      S_RUN: begin
        if (xfer) begin
          if (count != limit_q) begin
            count_n = count + 1'b1;
            // Residues step in lockstep with the count; a zero divisor just free-runs.
            for (int i = 0; i < NUM_DIV; i++) begin
              res_n[i] = (res[i] == div_q[i] - 1'b1) ? '0 : res[i] + 1'b1;
            end
          end else if (wrap_q) begin
            count_n = '0;
            res_n   = '0;
          end else begin
            state_n = S_IDLE;
            done_n  = 1'b1;
          end
        end
        if (stop) begin
          state_n = S_IDLE;
          done_n  = 1'b0;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Hits are computed from next-cycle residues so out_hit can be registered.
  generate
    for (genvar g = 0; g < NUM_DIV; g++) begin : g_hit
      assign hit_n[g] = (div_n[g] != '0) && (res_n[g] == '0);
    end
  endgenerate

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= S_IDLE;
      count   <= '0;
      limit_q <= '0;
      div_q   <= '0;
      res     <= '0;
      wrap_q  <= 1'b0;
      hit     <= '0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_n;
      count   <= count_n;
      limit_q <= limit_n;
      div_q   <= div_n;
      res     <= res_n;
      wrap_q  <= wrap_n;
      hit     <= hit_n;
      done_q  <= done_n;
    end
  end

  assign out_valid = (state == S_RUN);
  assign busy      = (state == S_RUN);
  assign out_count = count;
  assign out_hit   = hit;
  assign out_all   = &hit;
  assign out_none  = ~|hit;
  assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_fizzbuzz_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_fizzbuzz_stream
// Purpose  : Directed, table-driven self-checking bench for fizzbuzz_stream.
// Revision : 1.0
// ============================================================================
module tb_fizzbuzz_stream;
  localparam int CNT_W   = 8;
  localparam int NUM_DIV = 3;
  localparam int DIV_W   = 4;

  logic                     clk = 1'b0;
  logic                     resetn, start, stop, mode_wrap, out_ready;
  logic [CNT_W-1:0]         cfg_limit;
  logic [NUM_DIV*DIV_W-1:0] cfg_div;
  logic                     out_valid, out_all, out_none, busy, done;
  logic [CNT_W-1:0]         out_count;
  logic [NUM_DIV-1:0]       out_hit;

  fizzbuzz_stream #(.CNT_W(CNT_W), .NUM_DIV(NUM_DIV), .DIV_W(DIV_W)) dut (
    .clk(clk), .resetn(resetn), .start(start), .stop(stop),
    .mode_wrap(mode_wrap), .cfg_limit(cfg_limit), .cfg_div(cfg_div),
    .out_valid(out_valid), .out_ready(out_ready), .out_count(out_count),
    .out_hit(out_hit), .out_all(out_all), .out_none(out_none),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CNT_W-1:0]   count;
    logic [NUM_DIV-1:0] hit;
  } beat_t;

  beat_t seq15 [16];
  beat_t seqw  [7];
  int checks   = 0;
  int failures = 0;

  localparam logic [NUM_DIV*DIV_W-1:0] DIV_235 = {4'd5, 4'd3, 4'd2};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_beat(input string tag, input beat_t b);
    chk({tag, "_valid"}, 32'(out_valid), 32'(1));
    chk({tag, "_count"}, 32'(out_count), 32'(b.count));
    chk({tag, "_hit"},   32'(out_hit),   32'(b.hit));
    chk({tag, "_all"},   32'(out_all),   32'(&b.hit));
    chk({tag, "_none"},  32'(out_none),  32'(~|b.hit));
  endtask

  // Called at a falling edge; returns at the falling edge where the first beat is visible.
  task automatic do_start(input logic [CNT_W-1:0] lim, input logic [NUM_DIV*DIV_W-1:0] dv,
                          input logic wr);
    start = 1'b1; cfg_limit = lim; cfg_div = dv; mode_wrap = wr;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    // Channel hit bits: {div5, div3, div2}
    seq15[0]  = '{count: 8'd0,  hit: 3'b111};
    seq15[1]  = '{count: 8'd1,  hit: 3'b000};
    seq15[2]  = '{count: 8'd2,  hit: 3'b001};
    seq15[3]  = '{count: 8'd3,  hit: 3'b010};
    seq15[4]  = '{count: 8'd4,  hit: 3'b001};
    seq15[5]  = '{count: 8'd5,  hit: 3'b100};
    seq15[6]  = '{count: 8'd6,  hit: 3'b011};
    seq15[7]  = '{count: 8'd7,  hit: 3'b000};
    seq15[8]  = '{count: 8'd8,  hit: 3'b001};
    seq15[9]  = '{count: 8'd9,  hit: 3'b010};
    seq15[10] = '{count: 8'd10, hit: 3'b101};
    seq15[11] = '{count: 8'd11, hit: 3'b000};
    seq15[12] = '{count: 8'd12, hit: 3'b011};
    seq15[13] = '{count: 8'd13, hit: 3'b000};
    seq15[14] = '{count: 8'd14, hit: 3'b001};
    seq15[15] = '{count: 8'd15, hit: 3'b110};
    // Wrap run, divisors {1, 0, 2}: bit2 always, bit1 never, bit0 on even counts
    seqw[0] = '{count: 8'd0, hit: 3'b101};
    seqw[1] = '{count: 8'd1, hit: 3'b100};
    seqw[2] = '{count: 8'd2, hit: 3'b101};
    seqw[3] = '{count: 8'd3, hit: 3'b100};
    seqw[4] = '{count: 8'd4, hit: 3'b101};
    seqw[5] = '{count: 8'd0, hit: 3'b101};
    seqw[6] = '{count: 8'd1, hit: 3'b100};

    resetn = 1'b0; start = 1'b0; stop = 1'b0; mode_wrap = 1'b0; out_ready = 1'b0;
    cfg_limit = '0; cfg_div = '0;

    // Reset values
    @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'(0));
    chk("rst_busy",  32'(busy),      32'(0));
    chk("rst_count", 32'(out_count), 32'(0));
    chk("rst_hit",   32'(out_hit),   32'(0));
    chk("rst_none",  32'(out_none),  32'(1));
    chk("rst_done",  32'(done),      32'(0));
    resetn = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", 32'(out_valid), 32'(0));

    // One-shot, limit 15, full throughput
    out_ready = 1'b1;
    do_start(8'd15, DIV_235, 1'b0);
    for (int k = 0; k < 16; k++) begin
      chk_beat($sformatf("t1_k%0d", k), seq15[k]);
      chk("t1_done_low", 32'(done), 32'(0));
      @(negedge clk);
    end
    chk("t1_end_valid", 32'(out_valid), 32'(0));
    chk("t1_end_busy",  32'(busy),      32'(0));
    chk("t1_done",      32'(done),      32'(1));
    @(negedge clk);
    chk("t1_done_once", 32'(done), 32'(0));

    // Same run with ready toggling: 32 cycles to the last transfer
    out_ready = 1'b0;
    do_start(8'd15, DIV_235, 1'b0);
    for (int c = 0; c < 32; c++) begin
      out_ready = (c % 2 == 1);
      chk_beat($sformatf("t2_c%0d", c), seq15[c/2]);
      chk("t2_done_low", 32'(done), 32'(0));
      @(negedge clk);
    end
    chk("t2_end_valid", 32'(out_valid), 32'(0));
    chk("t2_done",      32'(done),      32'(1));

    // Wrap mode, limit 4, divisors {1,0,2}
    out_ready = 1'b1;
    @(negedge clk);
    do_start(8'd4, {4'd1, 4'd0, 4'd2}, 1'b1);
    for (int k = 0; k < 7; k++) begin
      chk_beat($sformatf("t3_k%0d", k), seqw[k]);
      chk("t3_no_done", 32'(done), 32'(0));
      if (k == 6) stop = 1'b1;
      @(negedge clk);
    end
    stop = 1'b0;
    chk("t3_stop_valid", 32'(out_valid), 32'(0));
    chk("t3_stop_done",  32'(done),      32'(0));
    @(negedge clk);
    chk("t3_stop_done2", 32'(done), 32'(0));

    // Stop during the count-5 transfer
    do_start(8'd15, DIV_235, 1'b0);
    for (int k = 0; k < 6; k++) begin
      chk_beat($sformatf("t4_k%0d", k), seq15[k]);
      if (k == 5) stop = 1'b1;
      @(negedge clk);
    end
    stop = 1'b0;
    chk("t4_stop_valid", 32'(out_valid), 32'(0));
    chk("t4_stop_busy",  32'(busy),      32'(0));
    chk("t4_stop_done",  32'(done),      32'(0));
    @(negedge clk);
    chk("t4_stop_done2", 32'(done),      32'(0));
    chk("t4_idle_valid", 32'(out_valid), 32'(0));
    // Restart with start held high: it must be ignored once running
    start = 1'b1;
    @(negedge clk);
    chk_beat("t4_restart0", seq15[0]);
    @(negedge clk);
    chk_beat("t4_restart1", seq15[1]);
    @(negedge clk);
    chk_beat("t4_restart2", seq15[2]);
    start = 1'b0;
    stop  = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("t4_end_valid", 32'(out_valid), 32'(0));

    // Limit 0: exactly one beat
    start = 1'b1; cfg_limit = 8'd0; cfg_div = {4'd3, 4'd3, 4'd3}; mode_wrap = 1'b0;
    @(negedge clk);
    chk_beat("t5_beat", '{count: 8'd0, hit: 3'b111});
    @(negedge clk);
    start = 1'b0;
    chk("t5_valid", 32'(out_valid), 32'(0));
    chk("t5_done",  32'(done),      32'(1));
    @(negedge clk);
    chk("t5_done_once", 32'(done),      32'(0));
    chk("t5_idle_valid", 32'(out_valid), 32'(0));

    // Asynchronous reset at count 7
    do_start(8'd15, DIV_235, 1'b0);
    for (int k = 0; k < 7; k++) begin
      chk_beat($sformatf("t6_k%0d", k), seq15[k]);
      @(negedge clk);
    end
    chk_beat("t6_k7", seq15[7]);
    #2 resetn = 1'b0;
    #1;
    chk("t6_arst_valid", 32'(out_valid), 32'(0));
    chk("t6_arst_busy",  32'(busy),      32'(0));
    chk("t6_arst_count", 32'(out_count), 32'(0));
    chk("t6_arst_hit",   32'(out_hit),   32'(0));
    @(negedge clk);
    resetn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t6_no_beats", 32'(out_valid), 32'(0));
    end
    do_start(8'd0, {4'd4, 4'd0, 4'd0}, 1'b0);
    chk_beat("t6_after", '{count: 8'd0, hit: 3'b100});
    @(negedge clk);
    chk("t6_after_done", 32'(done), 32'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fizzbuzz_stream.md
# fizzbuzz_stream

Parametrised multi-divisor fizzbuzz generator with a valid/ready output stream. After a `start` pulse it counts from 0 up to a runtime limit and, for each count value, emits one beat carrying the count and a per-divisor hit mask. It supports run-time divisors, one-shot or wrap-around mode, an abort input and downstream backpressure. It sits as a stimulus/pattern source ahead of any consumer that accepts a valid/ready stream.

## Interface

Parameters:
- `CNT_W`, 8, width of the counter, the limit and `out_count`.
- `NUM_DIV`, 3, number of independent divisors/channels.
- `DIV_W`, 4, width of each divisor field.

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a run; sampled only in IDLE.
- `stop`  in  1  abort the current run; sampled only in RUN.
- `mode_wrap`  in  1  0 = one-shot, 1 = wrap to 0 after the limit; latched at start.
- `cfg_limit`  in  CNT_W  last count value, inclusive; latched at start.
- `cfg_div`  in  NUM_DIV*DIV_W  divisor i in bits [i*DIV_W +: DIV_W]; latched at start.
- `out_valid`  out  1  beat available.
- `out_ready`  in  1  consumer accepts the beat.
- `out_count`  out  CNT_W  current count value.
- `out_hit`  out  NUM_DIV  bit i = count divisible by divisor i.
- `out_all`  out  1  AND of `out_hit`.
- `out_none`  out  1  NOR of `out_hit`.
- `busy`  out  1  high in RUN.
- `done`  out  1  one-cycle pulse when a one-shot run completes.

## Operation

- **FSM states:** IDLE and RUN.
- **IDLE to RUN:** on `start`=1. At that edge the block latches `cfg_limit`, `cfg_div` and `mode_wrap`, sets the count to 0 and clears all residues to 0.
- **Start while in RUN:** `start` is ignored.
- **Residues, no `%` operator:** each channel keeps a residue `r_i`, width DIV_W, which tracks count mod div_i. `out_hit[i]` = (div_i != 0) && (r_i == 0).
  - Divisor 0 never hits.
  - Divisor 1 always hits.
- **Transfer:** `out_valid && out_ready`. On each transfer:
  - If count != limit: count += 1. Each `r_i` increments, or goes to 0 when `r_i == div_i-1`.
  - If count == limit and wrap is set: count and all residues go to 0, and the block stays in RUN.
  - If count == limit and one-shot: go to IDLE and pulse `done` in the next cycle.
- **Stop:** `stop`=1 in RUN moves the FSM to IDLE at that edge. `done` does not pulse.
  - If a transfer occurs in the same cycle, that beat counts as consumed.
  - `stop` has priority over continuation and over wrap.
- **No overflow:** the limit compare happens before increment, so the count never exceeds the limit. `cfg_limit` = 2^CNT_W-1 is legal.
- **Limit 0:** the run emits exactly one beat, count 0, with every nonzero-divisor channel hit.
- **Output validity:** outputs are meaningful only while `out_valid`=1. In IDLE, `out_count` and `out_hit` hold their last values.

## Timing

- **Reset values:** during reset and after release, state=IDLE, `out_valid`=0, `out_count`=0, `out_hit`=0, `busy`=0 and `done`=0. `out_all` and `out_none` are derived from `out_hit` (`out_none`=1).
- **Reset is asynchronous** and takes effect immediately, including mid-run. Configuration is lost.
- **`out_valid` equals `busy`.** Both rise on the edge after `start` is sampled, and the first beat is count 0 in that same cycle.
- **Throughput:** one beat per cycle while `out_ready`=1.
- **Backpressure:** with `out_valid`=1 and `out_ready`=0, `out_count`, `out_hit`, `out_all` and `out_none` hold stable.
- **`out_valid` never deasserts without a transfer**, except on `stop` or reset.
- **One-shot completion:** the final transfer happens at edge T. At T, `busy` and `out_valid` fall, and `done`=1 for exactly the cycle after T.
- **Start after done:** `start` is accepted in the same cycle `done` is high, since the FSM is already in IDLE.
- **Wrap:** the beat after the limit is count 0, with no bubble cycle.
- **Outputs** `out_count`, `out_hit` and `done` are registered. `out_all` and `out_none` are combinational from `out_hit`.

## Test plan

- Reset, then start with limit=15, div={2,3,5} for channels 0, 1 and 2, wrap=0, ready=1.
  - Required: 16 beats, counts 0..15.
  - count 0: `out_hit`=3'b111, `out_all`=1.
  - count 6: `out_hit`=3'b011.
  - count 7: `out_none`=1.
  - count 10: `out_hit`=3'b101.
  - `done` is high exactly 1 cycle after the count-15 transfer.
- Same config, with `out_ready` toggling on alternate cycles.
  - Required: identical beat sequence and stable outputs during stalls.
  - 32 cycles from the first beat to the last transfer.
- wrap=1, limit=4, div={2,0,1}.
  - Required: counts 0,1,2,3,4,0,1 with no gap.
  - `out_hit[1]` always 0, `out_hit[2]` always 1.
  - No `done` pulse.
- `stop` asserted during a count-5 transfer in a limit=15 run.
  - Required: count 5 consumed, `out_valid`=0 next cycle, no `done`.
  - A subsequent `start` restarts at count 0.
- limit=0, div={3,3,3}.
  - Required: a single beat, count 0, `out_all`=1.
  - `done` pulses.
  - `start` held high during RUN is ignored.
- Assert `resetn`=0 asynchronously mid-run at count 7 (between clock edges).
  - Required: `out_valid`, `busy` and `out_count` go to 0 immediately.
  - No beats until the next `start`.
